// File: rtl/mem_bist_master_pkg.sv
// Shared bus constants, exit codes and BIST state encoding
// for the PicoRV32 native memory interface.
package picorv_bus_pkg;

    localparam logic [31:0] EXIT_ADDR = 32'h2000_0000;
    localparam logic [31:0] RAM_LIMIT = 32'h0001_0000;

    localparam logic [31:0] EXIT_PASS     = 32'd2;
    localparam logic [31:0] EXIT_MISMATCH = 32'd3;
    localparam logic [31:0] EXIT_TIMEOUT  = 32'd4;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        W_WORD,
        R_WORD,
        W_BYTE,
        R_BYTE,
        EXIT,
        DONE
    } bist_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/mem_bist_master_if.sv
// PicoRV32 native memory bus: one request/ready handshake.
interface mem_bist_master_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_bist_master_lfsr.sv
// 32-bit right-shifting Galois LFSR pattern source.
module mem_bist_lfsr
    import picorv_bus_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            value <= 32'h1;
        end else if (load) begin
            // an all-zero state would lock up the register
            value <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (adv) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// Bus-initiator RAM self-test: word/byte write-readback over the
// RAM window, result reported by a write to the exit register.
module mem_bist_master
    import picorv_bus_pkg::*;
#(
    parameter int          NUM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] SEED      = 32'hACE1_2468,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    mem_bist_master_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [31:0]         fail_addr
);

    localparam int KW = $clog2(NUM_WORDS) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0] SEED_G = (SEED == 32'h0) ? 32'h1 : SEED;

    bist_state_t   state;
    bist_state_t   nxt_state;
    logic [KW-1:0] k;
    logic [TW-1:0] wcnt;
    logic          pend;
    logic          tmo;

    logic [31:0] p;
    logic        lf_load;
    logic        lf_adv;

    logic        start_ok;
    logic        xfer;
    logic        last;
    logic        is_data;
    logic        is_rd;
    logic [1:0]  lane;
    logic [31:0] bm;
    logic [31:0] exp_word;
    logic        mismatch;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wdata;
    logic [3:0]  nxt_wstrb;

    mem_bist_lfsr u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .load   (lf_load),
        .adv    (lf_adv),
        .seed   (SEED),
        .value  (p)
    );

    always_comb begin
        start_ok = start && (state == IDLE || state == DONE);
        xfer     = bus.mem_valid && bus.mem_ready;
        last     = (k == K_LAST);
        is_rd    = (state == R_WORD) || (state == R_BYTE);
        is_data  = is_rd || (state == W_WORD) || (state == W_BYTE);
        lane     = 2'(k);
        bm       = 32'hFF << {lane, 3'b000};
        exp_word = (state == R_WORD) ? p : ((p & ~bm) | (~p & bm));
        mismatch = is_rd && (bus.mem_rdata != exp_word);
        // pattern restarts from SEED on entry to every data state
        lf_load  = start_ok ||
                   (xfer && is_data && last && state != R_BYTE);
        lf_adv   = xfer && is_data && !last;
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            W_WORD:  nxt_state = R_WORD;
            R_WORD:  nxt_state = W_BYTE;
            W_BYTE:  nxt_state = R_BYTE;
            R_BYTE:  nxt_state = EXIT;
            default: nxt_state = state;
        endcase
    end

    always_comb begin
        nxt_addr  = BASE_ADDR + (32'(k) << 2);
        nxt_wdata = 32'h0;
        nxt_wstrb = 4'h0;
        unique case (1'b1)
            state == W_WORD: begin
                nxt_wdata = p;
                nxt_wstrb = 4'hF;
            end
            state == W_BYTE: begin
                nxt_wdata = ~p;
                nxt_wstrb = 4'b0001 << lane;
            end
            state == EXIT: begin
                nxt_addr  = EXIT_ADDR;
                nxt_wstrb = 4'hF;
                nxt_wdata = tmo               ? EXIT_TIMEOUT  :
                            (err_count != '0) ? EXIT_MISMATCH :
                                                EXIT_PASS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            k             <= '0;
            wcnt          <= '0;
            pend          <= 1'b0;
            tmo           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_addr     <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
        end else if (start_ok) begin
            state         <= W_WORD;
            k             <= '0;
            wcnt          <= '0;
            pend          <= 1'b0;
            tmo           <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_addr     <= '0;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= SEED_G;
            bus.mem_wstrb <= 4'hF;
        end else if (bus.mem_valid) begin
            if (bus.mem_ready) begin
                bus.mem_valid <= 1'b0;
                if (mismatch) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    if (err_count == '0)
                        fail_addr <= bus.mem_addr;
                end
                if (state == EXIT) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= !tmo && (err_count == '0);
                end else begin
                    // relaunch after a one-cycle gap
                    pend <= 1'b1;
                    if (last) begin
                        state <= nxt_state;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
            end else if (wcnt == T_LAST) begin
                bus.mem_valid <= 1'b0;
                if (state == EXIT) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b0;
                end else begin
                    tmo   <= 1'b1;
                    state <= EXIT;
                    pend  <= 1'b1;
                end
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end else if (pend) begin
            pend          <= 1'b0;
            wcnt          <= '0;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= nxt_addr;
            bus.mem_wdata <= nxt_wdata;
            bus.mem_wstrb <= nxt_wstrb;
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Scoreboarded bench: behavioural responder with fault modes,
// expected run results queued at start, checked on done.
module tb_mem_bist_master;
    import picorv_bus_pkg::*;

    localparam int          NW  = 4;
    localparam int          TMO = 16;
    localparam logic [31:0] SD  = 32'hACE1_2468;

    typedef struct {
        logic [31:0] code;
        logic        pass;
        logic [15:0] errs;
        logic [31:0] faddr;
        int          txns;
        int          lat;
        bit          memchk;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] fail_addr;

    mem_bist_master_if bus();

    mem_bist_master #(
        .NUM_WORDS (NW),
        .BASE_ADDR (32'h0),
        .SEED      (SD),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder fault modes, set by stimulus between runs
    bit corrupt = 0, ign_strb = 0, hang = 0, rand_lat = 0;

    logic [31:0] mem [0:16383];
    logic        rdy = 1'b0;
    logic [31:0] rd = '0;
    int          wcnt = 0, lat = 0;
    logic [31:0] exit_val = '0;
    int          exit_n = 0;

    assign bus.mem_ready = rdy;
    assign bus.mem_rdata = rd;

    always @(posedge clk) begin
        rdy <= 1'b0;
        if (bus.mem_valid && !rdy) begin
            if (hang && bus.mem_addr == 32'h4) begin
            end else if (wcnt >= lat) begin
                rdy  <= 1'b1;
                wcnt <= 0;
                lat  <= rand_lat ? int'($urandom_range(4, 0)) : 0;
                if (bus.mem_wstrb != 4'h0) begin
                    if (bus.mem_addr == EXIT_ADDR) begin
                        exit_val <= bus.mem_wdata;
                        exit_n   <= exit_n + 1;
                    end else if (bus.mem_addr < RAM_LIMIT) begin
                        for (int l = 0; l < 4; l++)
                            if (bus.mem_wstrb[l] || ign_strb)
                                mem[bus.mem_addr[15:2]][8*l +: 8]
                                    <= bus.mem_wdata[8*l +: 8];
                    end
                end else begin
                    rd <= mem[bus.mem_addr[15:2]] ^
                          ((corrupt && bus.mem_addr == 32'h8)
                           ? 32'h1 : 32'h0);
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    int   checks = 0, errors = 0;
    exp_t sb[$];
    int   start_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    logic pv = 0, pr = 0, rst_q = 0, dq = 0, bq = 0, gap_f = 0;
    int   run = 0, txns = 0, exit0 = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] p, w;
        if (!rst_q) begin
            chk("rst_valid", 32'(bus.mem_valid), 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_wdata", bus.mem_wdata, 0);
            chk("rst_wstrb", 32'(bus.mem_wstrb), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_pass", 32'(pass), 0);
            chk("rst_err", 32'(err_count), 0);
            chk("rst_faddr", fail_addr, 0);
            gap_f = 0;
        end else begin
            if (busy && !bq) begin
                txns  = 0;
                exit0 = exit_n;
            end
            if (gap_f) begin
                if (busy) chk("relaunch", 32'(bus.mem_valid), 1);
                gap_f = 0;
            end
            if (pv && pr) begin
                txns++;
                chk("gap_low", 32'(bus.mem_valid), 0);
                gap_f = 1;
            end else if (pv && !bus.mem_valid) begin
                chk("tmo_len", run, TMO);
            end
            if (done && !dq) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    chk("exit_code", exit_val, e.code);
                    chk("exit_writes", exit_n - exit0, 1);
                    chk("pass", 32'(pass), 32'(e.pass));
                    chk("err_count", 32'(err_count), 32'(e.errs));
                    chk("fail_addr", fail_addr, e.faddr);
                    chk("txns", txns, e.txns);
                    if (e.lat >= 0)
                        chk("done_edge", cyc - start_cyc, e.lat);
                    if (e.memchk) begin
                        p = SD;
                        for (int i = 0; i < NW; i++) begin
                            w = p;
                            w[8*i +: 8] = ~p[8*i +: 8];
                            chk("mem_word", mem[i], w);
                            p = step(p);
                        end
                    end
                end
            end
        end
        run   = bus.mem_valid ? run + 1 : 0;
        pv    = bus.mem_valid;
        pr    = bus.mem_ready;
        rst_q = resetn;
        dq    = done;
        bq    = busy;
    end

    task automatic kick();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            $display("FAIL %s: got no done expected done", nm);
            $fatal(1, "run did not finish");
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic run_case(input string nm, input exp_t e);
        sb.push_back(e);
        kick();
        wait_done(nm);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);

        run_case("ideal", '{EXIT_PASS, 1'b1, 16'd0, 32'h0, 17, 50, 1'b1});

        corrupt = 1;
        run_case("corrupt", '{EXIT_MISMATCH, 1'b0, 16'd2, 32'h8, 17, 50, 1'b0});
        corrupt = 0;

        ign_strb = 1;
        run_case("no_strb", '{EXIT_MISMATCH, 1'b0, 16'd4, 32'h0, 17, 50, 1'b0});
        ign_strb = 0;

        hang = 1;
        run_case("hang", '{EXIT_TIMEOUT, 1'b0, 16'd0, 32'h0, 2, -1, 1'b0});
        hang = 0;

        rand_lat = 1;
        run_case("rand", '{EXIT_PASS, 1'b1, 16'd0, 32'h0, 17, -1, 1'b0});
        rand_lat = 0;
        repeat (8) @(posedge clk);

        kick();
        n = 0;
        while (!(bus.mem_valid && bus.mem_wstrb == 4'h0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            $display("FAIL reach_read: got no read expected read");
            $fatal(1, "no read phase");
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);

        run_case("after_rst", '{EXIT_PASS, 1'b1, 16'd0, 32'h0, 17, 50, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Bus-initiator self-test engine for the PicoRV32 native memory interface: it stands in for the CPU on the mem_* bus, writes a pseudo-random pattern into the RAM window, reads it back, checks byte-lane write strobes, then reports the result through a write to the exit MMIO register at 0x2000_0000. It lets the memory/MMIO responder be brought up and regression-tested without firmware, and can run as a power-on RAM check before the CPU is released from reset.

## Interface
- NUM_WORDS, 256: words tested, ≥1; range BASE_ADDR .. BASE_ADDR+4*NUM_WORDS-4.
- BASE_ADDR, 32'h0000_0000: first tested byte address, word-aligned.
- SEED, 32'hACE1_2468: LFSR seed; 0 is replaced by 1.
- TIMEOUT, 1024: max cycles mem_valid may stay high without mem_ready.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle run request; ignored while busy.
- mem_valid  out  1  request valid.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables; 0 = read.
- mem_rdata  in  32  read data, sampled on the mem_ready edge.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  valid when done; 1 = no mismatch, no timeout.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- fail_addr  out  32  address of the first mismatch, 0 if none.

## Operation
- States: IDLE → W_WORD → R_WORD → W_BYTE → R_BYTE → EXIT → DONE. DONE + start → W_WORD. Each pass over k = 0..NUM_WORDS-1 goes to the next state after k = NUM_WORDS-1.
- At entry to each of the four data states the LFSR is reloaded with SEED. It advances once per completed transaction. It is a Galois LFSR with taps 32'h8020_0003, shift right.
- W_WORD: addr = BASE_ADDR+4k, wstrb 4'hF, wdata = P (current LFSR value).
- R_WORD: wstrb 0; expected = P.
- W_BYTE: lane = k[1:0], wstrb = 1<<lane, wdata = ~P.
- R_BYTE: expected = P with byte `lane` replaced by the same byte of ~P.
- Address arithmetic is 32-bit, modulo 2^32. The index counter is $clog2(NUM_WORDS)+1 bits wide.
- On a mismatch: err_count increments (saturating). The first mismatch of a run latches fail_addr. The test continues.
- Timeout: if the per-transaction cycle counter reaches TIMEOUT, mem_valid drops, the timeout flag is set, and the FSM goes straight to EXIT. If the EXIT write itself times out, the FSM goes to DONE.
- EXIT: one write to 32'h2000_0000 with wstrb 4'hF. wdata = 2 on pass, 3 on mismatch, 4 on timeout (timeout takes priority).
- Start from DONE clears done, pass, err_count, fail_addr and the timeout flag.

## Timing
- Reset values of all outputs: mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, busy 0, done 0, pass 0, err_count 0, fail_addr 0.
- resetn low mid-transaction: mem_valid is 0 after that edge. No completion is counted.
- All outputs are registered.
- The edge that samples start sets mem_valid=1 and busy=1.
- mem_addr, mem_wdata and mem_wstrb are stable while mem_valid is high.
- A transaction completes on the first edge with mem_valid && mem_ready. At that edge mem_valid drops.
- Mandatory gap: mem_valid stays 0 for exactly one cycle after each completion. This absorbs the stale mem_ready that a one-cycle-latency responder produces.
- With a one-cycle responder each transaction takes 3 cycles. done rises 3*(4*NUM_WORDS+1)-1 edges after the start edge, at the edge the exit write completes.
- busy falls on the same edge that done and pass rise.
- mem_ready while mem_valid=0 is ignored.
- start coinciding with the EXIT completion is ignored.

## Structure
- Package picorv_bus_pkg holds:
  - EXIT_ADDR and RAM_LIMIT (32'h0001_0000);
  - exit codes EXIT_PASS=2, EXIT_MISMATCH=3, EXIT_TIMEOUT=4;
  - LFSR_TAPS;
  - the bist_state_t enum.
- Sub-module mem_bist_lfsr: 32-bit Galois LFSR with load/advance inputs and a zero-seed guard.
- The FSM, counters and compare logic live in the top.

## Test plan
- Ideal one-cycle responder (64 KB model), NUM_WORDS=4, start pulse → 17 transactions, exit write of 2, done at edge 50, pass=1, err_count=0.
- Responder corrupts bit 0 of reads at 0x0000_0008 → err_count=2 (R_WORD and R_BYTE), fail_addr=0x0000_0008, exit wdata 3, pass=0.
- Responder ignores wstrb (writes all lanes) → R_BYTE fails for every word, err_count=NUM_WORDS, exit 3.
- Responder never asserts mem_ready at address 4, TIMEOUT=16 → mem_valid drops after 16 cycles, exit write of 4, pass=0.
- Random 1–5 cycle ready latency → pass=1, and mem_valid=0 exactly one cycle after every completion.
- resetn low for one cycle during R_WORD → all outputs at reset values. A following start runs to pass.
